// File: rtl/draw_timer_bar.sv
// draw_timer_bar: overlays a shrinking countdown bar onto the pixel stream
// coming from screen_switch. Every timing/RGB signal is delayed by one pclk.
// Game time advances on the rising edge of vblnk_in (one tick per frame).
// The bar width is only updated on that tick, so it never tears mid-frame.
module draw_timer_bar #(
  parameter int BAR_X   = 100,
  parameter int BAR_Y   = 20,
  parameter int BAR_H   = 16,
  parameter int STEP    = 20,
  parameter int SECONDS = 30,
  parameter int FPS     = 60,
  parameter int WARN    = 5
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        start,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        time_up,
  output logic        running
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [5:0]  SEC_FULL = 6'(SECONDS);
  localparam logic [5:0]  FRM_LAST = 6'(FPS - 1);
  localparam logic [5:0]  WARN_S   = 6'(WARN);
  localparam logic [11:0] X0       = 12'(BAR_X);
  localparam logic [11:0] Y0       = 12'(BAR_Y);
  localparam logic [11:0] Y1       = 12'(BAR_Y + BAR_H);
  localparam logic [11:0] STEP_W   = 12'(STEP);
  localparam logic [11:0] W_FULL   = 12'(SECONDS * STEP);

  localparam logic [11:0] RGB_OK   = 12'h0F0;
  localparam logic [11:0] RGB_WARN = 12'hF00;

  // Timing bundle carried through the one-cycle delay.
  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } tim_t;

  tim_t        tim_in, tim_q;
  logic [1:0]  state, state_nxt;
  logic [5:0]  sec_cnt, sec_nxt;
  logic [5:0]  frm_cnt, frm_nxt;
  logic        vblnk_q;
  logic        tick;
  logic        reload;
  logic        latch;
  logic [11:0] bar_w_nxt;
  logic [11:0] bar_w_q;
  logic        warn_q;
  logic        in_x, in_y, blank;
  logic [11:0] rgb_nxt;

  assign tim_in = '{hcount: hcount_in, vcount: vcount_in,
                    hsync: hsync_in, vsync: vsync_in,
                    hblnk: hblnk_in, vblnk: vblnk_in};

  // One tick per frame, at the start of vertical blanking.
  assign tick = vblnk_in & ~vblnk_q;

  // Countdown FSM next state; a start in IDLE/DONE takes priority over a
  // coincident tick, so the first counted tick is the one after the start.
  always_comb begin
    state_nxt = state;
    sec_nxt   = sec_cnt;
    frm_nxt   = frm_cnt;
    reload    = 1'b0;
    case (state)
      ST_IDLE: begin
        sec_nxt = SEC_FULL;
        frm_nxt = '0;
        if (start) begin
          reload    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (frm_cnt == FRM_LAST) begin
            frm_nxt = '0;
            sec_nxt = sec_cnt - 6'd1;
            if (sec_cnt == 6'd1) state_nxt = ST_DONE;
          end else begin
            frm_nxt = frm_cnt + 6'd1;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          reload    = 1'b1;
          sec_nxt   = SEC_FULL;
          frm_nxt   = '0;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        sec_nxt   = SEC_FULL;
        frm_nxt   = '0;
      end
    endcase
  end

  // Width and colour follow the post-update second count, so the cycle that
  // enters DONE already shows an empty bar.
  assign bar_w_nxt = {6'd0, sec_nxt} * STEP_W;
  assign latch     = tick | reload;

  // Countdown state, frame-edge detector and the frame-stable bar geometry.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sec_cnt <= SEC_FULL;
      frm_cnt <= '0;
      vblnk_q <= 1'b0;
      bar_w_q <= W_FULL;
      warn_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      sec_cnt <= sec_nxt;
      frm_cnt <= frm_nxt;
      vblnk_q <= vblnk_in;
      if (latch) begin
        bar_w_q <= bar_w_nxt;
        warn_q  <= (sec_nxt <= WARN_S);
      end
    end
  end

  // Bar hit test against the current input pixel; all compares unsigned.
  assign in_x  = (hcount_in >= X0) && (hcount_in < (X0 + bar_w_q));
  assign in_y  = (vcount_in >= Y0) && (vcount_in < Y1);
  assign blank = hblnk_in | vblnk_in;

  // Blanking always passes rgb_in through untouched.
  always_comb begin
    rgb_nxt = rgb_in;
    if (!blank && in_x && in_y) rgb_nxt = warn_q ? RGB_WARN : RGB_OK;
  end

  // One-cycle output register for the timing bundle and overlaid colour.
  always_ff @(posedge pclk) begin
    if (rst) begin
      tim_q   <= '0;
      rgb_out <= '0;
    end else begin
      tim_q   <= tim_in;
      rgb_out <= rgb_nxt;
    end
  end

  assign hcount_out = tim_q.hcount;
  assign vcount_out = tim_q.vcount;
  assign hsync_out  = tim_q.hsync;
  assign vsync_out  = tim_q.vsync;
  assign hblnk_out  = tim_q.hblnk;
  assign vblnk_out  = tim_q.vblnk;

  assign time_up = (state == ST_DONE);
  assign running = (state == ST_RUN);

endmodule

// File: tb/tb_draw_timer_bar.sv
// Bench for draw_timer_bar, built with SECONDS=3, FPS=2, WARN=1 so a whole
// countdown is 6 frame ticks. Full bar spans x 100..159, y 20..35.
module tb_draw_timer_bar;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [11:0] hcount_in = '0, vcount_in = '0, rgb_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic        start = 1'b0;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, time_up, running;

  int n_chk = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  draw_timer_bar #(.SECONDS(3), .FPS(2), .WARN(1)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start(start),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .time_up(time_up), .running(running)
  );

  typedef struct {
    logic [27:0] bundle;
    logic [11:0] rgb;
    logic        chkf;
    logic [1:0]  flags;
    string       nm;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic [11:0] h, v;
    logic        hb, vb;
    logic [11:0] rin, eout;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one pixel at the falling edge, push the expectation, then pop and
  // compare one step after the rising edge that registers it.
  task automatic step(input logic [11:0] h, v, input logic hs, vs, hb, vb,
                      input logic [11:0] rin, input logic st,
                      input logic [11:0] erg, input logic chkf,
                      input logic etu, ern, input string nm);
    exp_t e;
    @(negedge pclk);
    hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; rgb_in = rin; start = st;
    e.bundle = {h, v, hs, vs, hb, vb};
    e.rgb = erg; e.chkf = chkf; e.flags = {etu, ern}; e.nm = nm;
    sbq.push_back(e);
    @(posedge pclk); #1;
    start = 1'b0;
    if (sbq.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      chk({e.nm, " rgb"}, 32'(rgb_out), 32'(e.rgb));
      chk({e.nm, " bundle"},
          32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
          32'(e.bundle));
      if (e.chkf) chk({e.nm, " flags"}, 32'({time_up, running}), 32'(e.flags));
    end
  endtask

  // Visible pixel probe with blue background.
  task automatic pix(input logic [11:0] h, v, erg, input logic etu, ern, input string nm);
    step(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F, 1'b0, erg, 1'b1, etu, ern, nm);
  endtask

  // n frame ticks: a vblank-high cycle followed by a vblank-low cycle.
  task automatic vb_pulse(input int n, input logic etu, ern, input string nm);
    logic [11:0] r;
    for (int i = 0; i < n; i++) begin
      r = 12'($urandom);
      step(12'd120, 12'd600, 1'b0, 1'b1, 1'b1, 1'b1, r, 1'b0, r, 1'b1, etu, ern, nm);
      r = 12'($urandom);
      step(12'd120, 12'd25, 1'b1, 1'b0, 1'b1, 1'b0, r, 1'b0, r, 1'b1, etu, ern, nm);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge pclk);
    rst = 1'b1;
    hcount_in = 12'd5; vcount_in = 12'd25; hsync_in = 1'b1; vsync_in = 1'b1;
    hblnk_in = 1'b1; vblnk_in = 1'b1; rgb_in = 12'hFFF;
    @(posedge pclk); #1;
    chk({nm, " rgb_out"}, 32'(rgb_out), 32'h0);
    chk({nm, " counts"}, 32'({hcount_out, vcount_out}), 32'h0);
    chk({nm, " sync/blank"}, 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    chk({nm, " time_up"}, 32'(time_up), 32'h0);
    chk({nm, " running"}, 32'(running), 32'h0);
    @(negedge pclk);
    rst = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
  endtask

  initial begin
    logic [11:0] r;
    logic [11:0] v;

    tbl[0] = '{12'd100, 12'd20, 1'b0, 1'b0, 12'h00F, 12'h0F0};
    tbl[1] = '{12'd159, 12'd35, 1'b0, 1'b0, 12'h00F, 12'h0F0};
    tbl[2] = '{12'd160, 12'd20, 1'b0, 1'b0, 12'h00F, 12'h00F};
    tbl[3] = '{12'd100, 12'd36, 1'b0, 1'b0, 12'h00F, 12'h00F};
    tbl[4] = '{12'd99,  12'd20, 1'b0, 1'b0, 12'h00F, 12'h00F};
    tbl[5] = '{12'd100, 12'd19, 1'b0, 1'b0, 12'h00F, 12'h00F};
    tbl[6] = '{12'd130, 12'd28, 1'b0, 1'b0, 12'hABC, 12'h0F0};
    tbl[7] = '{12'd130, 12'd28, 1'b1, 1'b0, 12'hABC, 12'hABC};
    tbl[8] = '{12'd130, 12'd28, 1'b0, 1'b1, 12'h123, 12'h123};
    tbl[9] = '{12'd0,   12'd0,  1'b0, 1'b0, 12'h456, 12'h456};

    do_reset("reset");

    // Idle bar geometry and blanking pass-through.
    for (int i = 0; i < 10; i++)
      step(tbl[i].h, tbl[i].v, 1'b0, 1'b0, tbl[i].hb, tbl[i].vb, tbl[i].rin, 1'b0,
           tbl[i].eout, 1'b1, 1'b0, 1'b0, $sformatf("idle[%0d]", i));

    // Random pass-through with the bar rows masked out.
    for (int i = 0; i < 24; i++) begin
      r = 12'($urandom);
      v = 12'($urandom_range(40, 1000));
      step(12'($urandom), v, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           r, 1'b0, r, 1'b1, 1'b0, 1'b0, $sformatf("pass[%0d]", i));
    end

    // Countdown.
    step(12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h00F, 1'b1, 12'h00F, 1'b1, 1'b0, 1'b1, "start");
    pix(12'd159, 12'd25, 12'h0F0, 1'b0, 1'b1, "run full in");
    pix(12'd160, 12'd25, 12'h00F, 1'b0, 1'b1, "run full out");
    vb_pulse(2, 1'b0, 1'b1, "ticks1-2");
    pix(12'd139, 12'd25, 12'h0F0, 1'b0, 1'b1, "w40 in");
    pix(12'd140, 12'd25, 12'h00F, 1'b0, 1'b1, "w40 out");
    pix(12'd100, 12'd25, 12'h0F0, 1'b0, 1'b1, "w40 left");
    pix(12'd139, 12'd30, 12'h0F0, 1'b0, 1'b1, "w40 line30 in");
    pix(12'd140, 12'd30, 12'h00F, 1'b0, 1'b1, "w40 line30 out");
    pix(12'd139, 12'd25, 12'h0F0, 1'b0, 1'b1, "w40 stable in");
    pix(12'd141, 12'd25, 12'h00F, 1'b0, 1'b1, "w40 stable out");
    step(12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h00F, 1'b1, 12'h00F, 1'b1, 1'b0, 1'b1, "start in run");
    pix(12'd139, 12'd25, 12'h0F0, 1'b0, 1'b1, "start ignored");
    vb_pulse(2, 1'b0, 1'b1, "ticks3-4");
    pix(12'd100, 12'd25, 12'hF00, 1'b0, 1'b1, "w20 red left");
    pix(12'd119, 12'd35, 12'hF00, 1'b0, 1'b1, "w20 red right");
    pix(12'd120, 12'd25, 12'h00F, 1'b0, 1'b1, "w20 out");
    vb_pulse(1, 1'b0, 1'b1, "tick5");
    pix(12'd119, 12'd25, 12'hF00, 1'b0, 1'b1, "tick5 red");
    vb_pulse(1, 1'b1, 1'b0, "tick6");
    pix(12'd100, 12'd25, 12'h00F, 1'b1, 1'b0, "done no bar");

    // start colliding with a tick in DONE: start wins, tick not counted.
    step(12'd120, 12'd600, 1'b0, 1'b1, 1'b1, 1'b1, 12'h321, 1'b1, 12'h321, 1'b1, 1'b0, 1'b1, "collide");
    pix(12'd159, 12'd25, 12'h0F0, 1'b0, 1'b1, "restart full in");
    pix(12'd160, 12'd25, 12'h00F, 1'b0, 1'b1, "restart full out");
    vb_pulse(5, 1'b0, 1'b1, "rerun ticks1-5");
    vb_pulse(1, 1'b1, 1'b0, "rerun tick6");

    // Reset in the middle of a run.
    step(12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h00F, 1'b1, 12'h00F, 1'b1, 1'b0, 1'b1, "start3");
    vb_pulse(3, 1'b0, 1'b1, "mid ticks");
    pix(12'd139, 12'd25, 12'h0F0, 1'b0, 1'b1, "mid w40 in");
    pix(12'd140, 12'd25, 12'h00F, 1'b0, 1'b1, "mid w40 out");
    do_reset("midreset");
    vb_pulse(1, 1'b0, 1'b0, "post reset frame");
    pix(12'd159, 12'd25, 12'h0F0, 1'b0, 1'b0, "post reset full in");
    pix(12'd160, 12'd25, 12'h00F, 1'b0, 1'b0, "post reset full out");
    vb_pulse(3, 1'b0, 1'b0, "idle hold");
    pix(12'd159, 12'd25, 12'h0F0, 1'b0, 1'b0, "idle hold full");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
